// File: rtl/game_stats_bcd.sv
// game_stats_bcd: score / cleared-lines / level counters kept as packed BCD
// for the drawing stage. All arithmetic is digit-serial on shadow copies;
// the visible outputs change only on the single COMMIT cycle.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   new_game_i            synchronous clear of everything, highest priority
//   lines_valid_i         line-clear event strobe, taken only while ready_o
//   lines_cnt_i[2:0]      rows cleared (1..4); other values drop the event
//   soft_drop_i           one-row soft-drop pulse (see macro below)
//   ready_o               idle, an event can be accepted this cycle
//   score_o/lines_o/level_o  packed BCD, digit 0 least significant
//   level_up_o            one-cycle pulse on the commit that raises the level
//
// Optional feature macro: GAME_STATS_SOFT_DROP_EN adds a +1 score pass per
// accepted soft_drop_i pulse. Without it soft_drop_i is ignored.
// DIGITS must be at least 4 so the 1200-point base fits.
module game_stats_bcd #(
  parameter int DIGITS          = 6,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 99
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  new_game_i,
  input  logic                  lines_valid_i,
  input  logic [2:0]            lines_cnt_i,
  input  logic                  soft_drop_i,
  output logic                  ready_o,
  output logic [DIGITS*4-1:0]   score_o,
  output logic [DIGITS*4-1:0]   lines_o,
  output logic [DIGITS*4-1:0]   level_o,
  output logic                  level_up_o
);

  localparam int W  = DIGITS * 4;
  localparam int LW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL + 1) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // to_next plus the largest event (4) must fit without wrapping
  localparam int TW = $clog2(LINES_PER_LEVEL + 4);
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, SCORE, LINES, COMMIT} state_t;

  state_t          state_q, state_d;

  logic [W-1:0]    score_q, lines_q, level_q;
  logic [LW-1:0]   lvl_q;
  logic [W-1:0]    sh_score, sh_lines;
  logic [W-1:0]    base_q;
  logic [2:0]      n_q;
  logic [LW-1:0]   pass_q;     // additions still to run after the current one
  logic [IW-1:0]   idx_q;      // digit being processed
  logic            carry_q;
  logic [TW-1:0]   to_next_q;
  logic            up_flag_q;
  logic            level_up_q;

  logic            cnt_ok, accept_ev, accept_sd, sd_pass, last_digit;
  logic [W-1:0]    base_pts;
  logic [3:0]      add_a, add_b, dig_sum;
  logic [4:0]      raw;
  logic            dig_cy;
  logic [TW-1:0]   tn_sum;

  assign ready_o    = (state_q == IDLE);
  assign score_o    = score_q;
  assign lines_o    = lines_q;
  assign level_o    = level_q;
  assign level_up_o = level_up_q;

  assign cnt_ok     = (lines_cnt_i != 3'd0) && (lines_cnt_i <= 3'd4);
  assign accept_ev  = ready_o && lines_valid_i && cnt_ok && !new_game_i;
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign tn_sum     = to_next_q + TW'(n_q);

`ifdef GAME_STATS_SOFT_DROP_EN
  // Any lines_valid_i (even with a bad count) pre-empts a soft drop.
  assign accept_sd = ready_o && soft_drop_i && !lines_valid_i && !new_game_i;

  // Marks a soft-drop pass so SCORE goes straight to COMMIT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sd_pass <= 1'b0;
    end else if (new_game_i) begin
      sd_pass <= 1'b0;
    end else if (state_q == IDLE) begin
      sd_pass <= accept_sd;
    end
  end
`else
  logic unused_soft_drop;
  assign unused_soft_drop = soft_drop_i;
  assign accept_sd        = 1'b0;
  assign sd_pass          = 1'b0;
`endif

  always_comb begin
    base_pts = '0;
    case (lines_cnt_i)
      3'd1:    base_pts = W'(16'h0040);
      3'd2:    base_pts = W'(16'h0100);
      3'd3:    base_pts = W'(16'h0300);
      3'd4:    base_pts = W'(16'h1200);
      default: base_pts = '0;
    endcase
  end

  // One BCD digit adder shared by the SCORE and LINES phases.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_q == SCORE) begin
      add_a = sh_score[idx_q*4 +: 4];
      add_b = base_q[idx_q*4 +: 4];
    end else begin
      add_a = sh_lines[idx_q*4 +: 4];
      add_b = (idx_q == '0) ? {1'b0, n_q} : 4'd0;
    end
    raw = {1'b0, add_a} + {1'b0, add_b} + {4'd0, carry_q};
    if (raw > 5'd9) begin
      dig_sum = raw[3:0] + 4'd6;
      dig_cy  = 1'b1;
    end else begin
      dig_sum = raw[3:0];
      dig_cy  = 1'b0;
    end
  end

  function automatic logic [W-1:0] bin2bcd(input logic [LW-1:0] v);
    logic [W-1:0] b;
    b = '0;
    for (int i = LW - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (b[d*4 +: 4] >= 4'd5) b[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
      end
      b = {b[W-2:0], v[i]};
    end
    return b;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_ev || accept_sd) state_d = SCORE;
      SCORE:   if (last_digit && pass_q == '0) state_d = sd_pass ? COMMIT : LINES;
      LINES:   if (last_digit) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (new_game_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      score_q    <= '0;
      lines_q    <= '0;
      level_q    <= '0;
      lvl_q      <= '0;
      sh_score   <= '0;
      sh_lines   <= '0;
      base_q     <= '0;
      n_q        <= '0;
      pass_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      to_next_q  <= '0;
      up_flag_q  <= 1'b0;
      level_up_q <= 1'b0;
    end else begin
      level_up_q <= 1'b0;
      if (new_game_i) begin
        score_q   <= '0;
        lines_q   <= '0;
        level_q   <= '0;
        lvl_q     <= '0;
        sh_score  <= '0;
        sh_lines  <= '0;
        pass_q    <= '0;
        idx_q     <= '0;
        carry_q   <= 1'b0;
        to_next_q <= '0;
        up_flag_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept_ev || accept_sd) begin
              sh_score  <= score_q;
              sh_lines  <= lines_q;
              idx_q     <= '0;
              carry_q   <= 1'b0;
              up_flag_q <= 1'b0;
              n_q       <= lines_cnt_i;
              if (accept_ev) begin
                base_q <= base_pts;
                pass_q <= lvl_q;          // L+1 passes in total
              end else begin
                base_q <= W'(1);
                pass_q <= '0;
              end
            end
          end
          SCORE: begin
            sh_score[idx_q*4 +: 4] <= dig_sum;
            carry_q <= dig_cy;
            if (last_digit) begin
              idx_q   <= '0;
              carry_q <= 1'b0;
              // carry out of the top digit: clamp; later passes re-clamp
              if (dig_cy) sh_score <= NINES;
              if (pass_q != '0) pass_q <= pass_q - 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          LINES: begin
            sh_lines[idx_q*4 +: 4] <= dig_sum;
            carry_q <= dig_cy;
            if (idx_q == '0) begin
              if (tn_sum >= TW'(LINES_PER_LEVEL)) begin
                to_next_q <= tn_sum - TW'(LINES_PER_LEVEL);
                up_flag_q <= 1'b1;
              end else begin
                to_next_q <= tn_sum;
              end
            end
            if (last_digit) begin
              idx_q   <= '0;
              carry_q <= 1'b0;
              if (dig_cy) sh_lines <= NINES;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          COMMIT: begin
            score_q   <= sh_score;
            lines_q   <= sh_lines;
            up_flag_q <= 1'b0;
            if (up_flag_q && (lvl_q < LW'(MAX_LEVEL))) begin
              lvl_q      <= lvl_q + 1'b1;
              level_q    <= bin2bcd(lvl_q + 1'b1);
              level_up_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
